opb_addr_router: RTL and testbench

- Parametrised OPB address router that replaces the fixed 12-peripheral decoder.
- Decodes OPB_RE/OPB_WE into per-slave strobes for NUM_SLV base/size windows, and returns read data to the OPB master.
- Supports two kinds of slave:
  - fixed-latency (legacy, data valid one cycle after RE);
  - handshake (wait states, slave asserts ACK).
- Adds unmapped-access, collision and protocol-error detection with error capture. Sits between the OPB master and all peripheral register blocks.

---
 rtl/opb_addr_router_pkg.sv | 23 ++
 rtl/opb_addr_router_if.sv | 29 ++
 rtl/opb_addr_router_range_match.sv | 14 +
 rtl/opb_addr_router.sv | 138 +++++++++++++
 tb/tb_opb_addr_router.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/opb_addr_router_pkg.sv
// Shared constants and FSM encoding for the OPB address router.
package opb_addr_router_pkg;

  localparam int          OPB_ADDR_W       = 32;
  localparam int          OPB_DATA_W       = 32;
  localparam logic [31:0] OPB_TIMEOUT_DATA = 32'hBAD0_BAD0;

  // Legacy peripheral window used for the default base/size map
  localparam logic [31:0] OPB_PERIPH_BASE  = 32'h0000_0000;
  localparam logic [31:0] OPB_PERIPH_SIZE  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_FIX,
    ST_RD_WAIT,
    ST_ERR
  } opb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/opb_addr_router_if.sv
// OPB master-side and peripheral-side signals of the address router.
interface opb_addr_router_if #(
  parameter int NUM_SLV = 12,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic                             OPB_RE;
  logic                             OPB_WE;
  logic [ADDR_W-1:0]                OPB_ADDR;
  logic [DATA_W-1:0]                OPB_DO;
  logic                             OPB_RDY;
  logic                             OPB_ERR;
  logic [NUM_SLV-1:0]               SLV_RE;
  logic [NUM_SLV-1:0]               SLV_WE;
  logic [NUM_SLV-1:0][DATA_W-1:0]   SLV_DI;
  logic [NUM_SLV-1:0]               SLV_ACK;
  logic [ADDR_W-1:0]                ERR_ADDR;
  logic [7:0]                       ERR_CNT;

  modport slave (
    input  OPB_RE, OPB_WE, OPB_ADDR, SLV_DI, SLV_ACK,
    output OPB_DO, OPB_RDY, OPB_ERR, SLV_RE, SLV_WE, ERR_ADDR, ERR_CNT
  );

  modport master (
    output OPB_RE, OPB_WE, OPB_ADDR, SLV_DI, SLV_ACK,
    input  OPB_DO, OPB_RDY, OPB_ERR, SLV_RE, SLV_WE, ERR_ADDR, ERR_CNT
  );
endinterface

// File: rtl/opb_addr_router_range_match.sv
// Single window decode: addr in [base, base+size), limit kept one bit wider.
module opb_range_match #(
  parameter int ADDR_W = 32
)(
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] size,
  output logic              hit
);
  logic [ADDR_W:0] lim;

  assign lim = {1'b0, base} + {1'b0, size};
  assign hit = (addr >= base) && ({1'b0, addr} < lim);
endmodule

// File: rtl/opb_addr_router.sv
// Parametrised OPB address router: window decode, read return, error capture.
// Optional read timeout on handshake slots: define OPB_DEC_TIMEOUT_EN.
module opb_addr_router
  import opb_addr_router_pkg::*;
#(
  parameter int                        NUM_SLV     = 12,
  parameter int                        ADDR_W      = OPB_ADDR_W,
  parameter int                        DATA_W      = OPB_DATA_W,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = {NUM_SLV{ADDR_W'(OPB_PERIPH_BASE)}},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_SIZE    = {NUM_SLV{ADDR_W'(OPB_PERIPH_SIZE)}},
  parameter logic [NUM_SLV-1:0]        SLV_HS_MASK = '0,
  parameter int                        TIMEOUT_CYC = 255
)(
  input  logic              OPB_CLK,
  input  logic              OPB_RST,
  opb_addr_router_if.slave  bus
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 32 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("opb_addr_router: unsupported NUM_SLV or TIMEOUT_CYC");
  end

  opb_state_e         state_q, state_d;
  logic [NUM_SLV-1:0] hit;
  logic [SEL_W-1:0]   hit_idx, sel_q;
  logic               any_hit, strobe, rd_ack, tmo, err_pend_q;
  logic [ADDR_W-1:0]  pend_addr_q, tmo_addr;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slot
    opb_range_match #(.ADDR_W(ADDR_W)) u_match (
      .addr (bus.OPB_ADDR),
      .base (SLV_BASE[i*ADDR_W +: ADDR_W]),
      .size (SLV_SIZE[i*ADDR_W +: ADDR_W]),
      .hit  (hit[i])
    );
  end

  // Lowest index wins on overlapping windows
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if (hit[i]) hit_idx = SEL_W'(i);
  end

  assign any_hit = |hit;
  assign strobe  = bus.OPB_RE | bus.OPB_WE;
  assign rd_ack  = (state_q == ST_RD_WAIT) && bus.SLV_ACK[sel_q];

`ifdef OPB_DEC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]   to_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;

  // Counter sits at zero outside RD_WAIT, so it is clear on every entry
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      to_cnt_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      to_cnt_q  <= (state_q == ST_RD_WAIT) ? to_cnt_q + 1'b1 : '0;
      if (state_q == ST_IDLE) rd_addr_q <= bus.OPB_ADDR;
    end
  end

  assign tmo      = (state_q == ST_RD_WAIT) && !rd_ack &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign tmo_addr = rd_addr_q;
`else
  assign tmo      = 1'b0;
  assign tmo_addr = '0;
`endif

  always_comb begin
    state_d     = state_q;
    bus.SLV_RE  = '0;
    bus.SLV_WE  = '0;
    bus.OPB_RDY = 1'b0;
    bus.OPB_DO  = '0;
    case (state_q)
      ST_IDLE: begin
        if ((bus.OPB_RE && bus.OPB_WE) || (strobe && !any_hit)) begin
          state_d = ST_ERR;
        end else if (bus.OPB_RE) begin
          bus.SLV_RE[hit_idx] = 1'b1;
          state_d = SLV_HS_MASK[hit_idx] ? ST_RD_WAIT : ST_RD_FIX;
        end else if (bus.OPB_WE) begin
          bus.SLV_WE[hit_idx] = 1'b1;
        end
      end
      ST_RD_FIX: begin
        bus.OPB_RDY = 1'b1;
        bus.OPB_DO  = bus.SLV_DI[sel_q];
        state_d     = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rd_ack) begin
          bus.OPB_RDY = 1'b1;
          bus.OPB_DO  = bus.SLV_DI[sel_q];
          state_d     = ST_IDLE;
        end else if (tmo) begin
          bus.OPB_RDY = 1'b1;
          bus.OPB_DO  = DATA_W'(OPB_TIMEOUT_DATA);
          state_d     = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bad IDLE accesses go through ST_ERR; strobes during a busy state raise
  // err_pend_q instead so the pending read is left untouched.
  assign bus.OPB_ERR = (state_q == ST_ERR) | err_pend_q | tmo;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      err_pend_q   <= 1'b0;
      pend_addr_q  <= '0;
      bus.ERR_ADDR <= '0;
      bus.ERR_CNT  <= '0;
    end else begin
      state_q    <= state_d;
      err_pend_q <= strobe && (state_q != ST_IDLE);
      if (strobe && ((state_q != ST_IDLE) || (state_d == ST_ERR)))
        pend_addr_q <= bus.OPB_ADDR;
      if (state_q == ST_IDLE)
        sel_q <= hit_idx;
      if (bus.OPB_ERR) begin
        bus.ERR_ADDR <= (tmo && !err_pend_q) ? tmo_addr : pend_addr_q;
        bus.ERR_CNT  <= sat_inc8(bus.ERR_CNT);
      end
    end
  end

endmodule

// File: tb/tb_opb_addr_router.sv
// Directed bench for opb_addr_router: 4 slots (0 fixed, 1 handshake, 2/3 overlap).
module tb_opb_addr_router;
  localparam int NS = 4;

  logic OPB_CLK = 1'b0;
  logic OPB_RST = 1'b1;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   exp_cnt = 0;

  always #5 OPB_CLK = ~OPB_CLK;

  opb_addr_router_if #(.NUM_SLV(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  opb_addr_router #(
    .NUM_SLV     (NS),
    .ADDR_W      (32),
    .DATA_W      (32),
    .SLV_BASE    ({32'h3000, 32'h3000, 32'h1000, 32'h0000}),
    .SLV_SIZE    ({32'h0200, 32'h0100, 32'h0100, 32'h0100}),
    .SLV_HS_MASK (4'b0010),
    .TIMEOUT_CYC (8)
  ) dut (
    .OPB_CLK (OPB_CLK),
    .OPB_RST (OPB_RST),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge OPB_CLK);
  endtask

  task automatic strobe(input logic re, input logic we, input logic [31:0] a);
    bus.OPB_RE   = re;
    bus.OPB_WE   = we;
    bus.OPB_ADDR = a;
  endtask

  initial begin
    strobe(1'b0, 1'b0, 32'h0);
    bus.SLV_ACK   = '0;
    bus.SLV_DI[0] = 32'h1234_5678;
    bus.SLV_DI[1] = 32'h0;
    bus.SLV_DI[2] = 32'h2222_0002;
    bus.SLV_DI[3] = 32'h3333_0003;

    // Reset state
    cyc(); cyc();
    chk("rst_rdy",   32'(bus.OPB_RDY),  32'h0);
    chk("rst_err",   32'(bus.OPB_ERR),  32'h0);
    chk("rst_do",    bus.OPB_DO,        32'h0);
    chk("rst_sre",   32'(bus.SLV_RE),   32'h0);
    chk("rst_swe",   32'(bus.SLV_WE),   32'h0);
    chk("rst_eaddr", bus.ERR_ADDR,      32'h0);
    chk("rst_ecnt",  32'(bus.ERR_CNT),  32'h0);
    OPB_RST = 1'b0;
    cyc();

    // Unmapped write
    strobe(1'b0, 1'b1, 32'h2000); #1;
    chk("unm_swe", 32'(bus.SLV_WE), 32'h0);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("unm_err", 32'(bus.OPB_ERR), 32'h1);
    cyc(); exp_cnt = 1;
    chk("unm_err_lo", 32'(bus.OPB_ERR), 32'h0);
    chk("unm_eaddr",  bus.ERR_ADDR,     32'h2000);
    chk("unm_ecnt",   32'(bus.ERR_CNT), 32'(exp_cnt));

    // Fixed-latency read on slot 0
    strobe(1'b1, 1'b0, 32'h10); #1;
    chk("fix_sre",  32'(bus.SLV_RE),  32'h1);
    chk("fix_rdy0", 32'(bus.OPB_RDY), 32'h0);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("fix_rdy", 32'(bus.OPB_RDY), 32'h1);
    chk("fix_do",  bus.OPB_DO,       32'h1234_5678);
    cyc();
    chk("fix_rdy_lo", 32'(bus.OPB_RDY), 32'h0);
    chk("fix_do_lo",  bus.OPB_DO,       32'h0);

    // Handshake read on slot 1 with a dropped RE in wait cycle 2
    strobe(1'b1, 1'b0, 32'h1004); #1;
    chk("hs_sre", 32'(bus.SLV_RE), 32'h2);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("hs_w1_rdy", 32'(bus.OPB_RDY), 32'h0);
    cyc(); strobe(1'b1, 1'b0, 32'h20); #1;
    chk("hs_drop_sre", 32'(bus.SLV_RE), 32'h0);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("hs_viol_err", 32'(bus.OPB_ERR), 32'h1);
    chk("hs_w3_rdy",   32'(bus.OPB_RDY), 32'h0);
    cyc(); bus.SLV_ACK = 4'b0001; #1; exp_cnt++;
    chk("hs_other_ack", 32'(bus.OPB_RDY),  32'h0);
    chk("hs_viol_addr", bus.ERR_ADDR,      32'h20);
    chk("hs_viol_cnt",  32'(bus.ERR_CNT),  32'(exp_cnt));
    cyc(); bus.SLV_ACK = 4'b0010; bus.SLV_DI[1] = 32'hA5A5_0001; #1;
    chk("hs_rdy", 32'(bus.OPB_RDY), 32'h1);
    chk("hs_do",  bus.OPB_DO,       32'hA5A5_0001);
    cyc(); bus.SLV_ACK = '0; #1;
    chk("hs_rdy_lo", 32'(bus.OPB_RDY), 32'h0);

    // Overlapping windows 2/3: lowest index takes the read, 0x3100 only in slot 3
    strobe(1'b1, 1'b0, 32'h3000); #1;
    chk("ovl_sre", 32'(bus.SLV_RE), 32'h4);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("ovl_do", bus.OPB_DO, 32'h2222_0002);
    cyc(); strobe(1'b0, 1'b1, 32'h3100); #1;
    chk("ovl_swe", 32'(bus.SLV_WE), 32'h8);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("wr_no_rdy", 32'(bus.OPB_RDY), 32'h0);
    chk("wr_no_err", 32'(bus.OPB_ERR), 32'h0);

    // RE and WE together
    strobe(1'b1, 1'b1, 32'h10); #1;
    chk("col_sre", 32'(bus.SLV_RE), 32'h0);
    chk("col_swe", 32'(bus.SLV_WE), 32'h0);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("col_err", 32'(bus.OPB_ERR), 32'h1);
    cyc(); exp_cnt++;
    chk("col_eaddr", bus.ERR_ADDR,     32'h10);
    chk("col_ecnt",  32'(bus.ERR_CNT), 32'(exp_cnt));

    // Window edges: 0xFF inside slot 0, 0x100 just past it
    strobe(1'b1, 1'b0, 32'hFF); #1;
    chk("edge_in_sre", 32'(bus.SLV_RE), 32'h1);
    cyc(); strobe(1'b1, 1'b1, 32'h0); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("edge_in_do", bus.OPB_DO, 32'h1234_5678);
    cyc(); strobe(1'b1, 1'b0, 32'h100); #1;
    chk("edge_out_sre", 32'(bus.SLV_RE), 32'h0);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("edge_out_err", 32'(bus.OPB_ERR), 32'h1);
    cyc(); exp_cnt++;
    chk("edge_out_eaddr", bus.ERR_ADDR, 32'h100);

`ifdef OPB_DEC_TIMEOUT_EN
    // Handshake read with no ACK expires in the 8th wait cycle
    strobe(1'b1, 1'b0, 32'h1008); #1;
    chk("to_sre", 32'(bus.SLV_RE), 32'h2);
    for (int k = 1; k <= 7; k++) begin
      cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
      chk("to_wait_rdy", 32'(bus.OPB_RDY), 32'h0);
    end
    cyc(); #1;
    chk("to_rdy", 32'(bus.OPB_RDY), 32'h1);
    chk("to_err", 32'(bus.OPB_ERR), 32'h1);
    chk("to_do",  bus.OPB_DO,       32'hBAD0_BAD0);
    cyc(); exp_cnt++;
    chk("to_rdy_lo", 32'(bus.OPB_RDY),  32'h0);
    chk("to_eaddr",  bus.ERR_ADDR,      32'h1008);
    chk("to_ecnt",   32'(bus.ERR_CNT),  32'(exp_cnt));
`endif

    // Error counter saturation
    chk("pre_sat_cnt", 32'(bus.ERR_CNT), 32'(exp_cnt));
    for (int k = 0; k < 300; k++) begin
      strobe(1'b0, 1'b1, 32'h2000);
      cyc(); strobe(1'b0, 1'b0, 32'h0);
      cyc();
    end
    chk("sat_cnt", 32'(bus.ERR_CNT), 32'hFF);

    // Reset while waiting on a handshake read
    strobe(1'b1, 1'b0, 32'h1000);
    cyc(); strobe(1'b0, 1'b0, 32'h0);
    cyc(); OPB_RST = 1'b1; #1;
    chk("mrst_rdy",   32'(bus.OPB_RDY), 32'h0);
    chk("mrst_err",   32'(bus.OPB_ERR), 32'h0);
    chk("mrst_ecnt",  32'(bus.ERR_CNT), 32'h0);
    chk("mrst_eaddr", bus.ERR_ADDR,     32'h0);
    bus.SLV_ACK = 4'b0010;
    cyc(); OPB_RST = 1'b0; #1;
    chk("mrst_ack_rdy", 32'(bus.OPB_RDY), 32'h0);
    bus.SLV_ACK = '0;
    cyc(); strobe(1'b1, 1'b0, 32'h10); #1;
    chk("post_sre", 32'(bus.SLV_RE), 32'h1);
    cyc(); strobe(1'b0, 1'b0, 32'h0); #1;
    chk("post_rdy", 32'(bus.OPB_RDY), 32'h1);
    chk("post_do",  bus.OPB_DO,       32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
